usb3_rx_fifo_if: RTL

//  Parametrised FT601/FT600 245-synchronous-FIFO receive interface with an integrated show-ahead FIFO.

---
 rtl/usb3_rx_fifo_if.sv | 129 ++++++++++++
 1 files changed

// File: rtl/usb3_rx_fifo_if.sv
// FT601/FT600 245-synchronous-FIFO receive interface with an integrated show-ahead buffer.
// Runs the OE_N/RD_N burst handshake and stops early enough that the trailing word still fits.
module usb3_rx_fifo_if #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned LINE_WORDS   = 40,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                          ftdi_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          FR_RXF,
  output logic                          FT_OE,
  output logic                          FT_RD,
  input  logic [DATA_W-1:0]             usb3_data_in,
  output logic                          fifo_empty,
  output logic                          full_dataline_available,
  input  logic                          get_next_word,
  output logic [DATA_W-1:0]             fifo_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STOP_C  = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [CNT_W-1:0] LINE_C  = CNT_W'(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    READ = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ft_oe_q, ft_oe_d;
  logic                ft_rd_q, ft_rd_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, empty_d;
  logic                line_q, line_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                wr, wr_ok, rd, full;
  logic [PTR_W-1:0]    rd_ptr_nxt;

  // Buffer bookkeeping: strobes, pointers, occupancy and the show-ahead head word
  always_comb begin
    full       = (count_q == DEPTH_C);
    wr         = (state_q == READ) && !FR_RXF;
    wr_ok      = wr && !full;
    rd         = get_next_word && (count_q != '0);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    wr_ptr_d   = wr_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = rd ? rd_ptr_nxt : rd_ptr_q;
    count_d    = count_q + CNT_W'(wr_ok) - CNT_W'(rd);
    empty_d    = (count_d == '0);
    line_d     = (count_d >= LINE_C);
    overflow_d = overflow_q | (wr && full);

    // Incoming word becomes the head when it lands in an empty (or emptying) buffer
    head_d = head_q;
    if (wr_ok && ((count_q == '0) || ((count_q == CNT_W'(1)) && rd))) begin
      head_d = usb3_data_in;
    end else if (rd) begin
      head_d = mem_q[rd_ptr_nxt];
    end
  end

  // Burst handshake; READ exits once the post-edge level reaches the reserve threshold
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable && !FR_RXF && (count_q < STOP_C)) state_d = ARM;
      ARM:  state_d = (FR_RXF || !enable) ? IDLE : READ;
      READ: if (FR_RXF || !enable || (count_d >= STOP_C)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ft_oe_d = !((state_d == ARM) || (state_d == READ));
    ft_rd_d = (state_d != READ);
  end

  always_ff @(posedge ftdi_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ft_oe_q    <= 1'b1;
      ft_rd_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      line_q     <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      ft_oe_q    <= ft_oe_d;
      ft_rd_q    <= ft_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      line_q     <= line_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  // Storage array carries no reset; occupancy tracking decides what is valid
  always_ff @(posedge ftdi_clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_ptr_q] <= usb3_data_in;
    end
  end

  assign FT_OE                   = ft_oe_q;
  assign FT_RD                   = ft_rd_q;
  assign fifo_empty              = empty_q;
  assign full_dataline_available = line_q;
  assign fifo_data_out           = head_q;
  assign fifo_count              = count_q;
  assign overflow                = overflow_q;

endmodule
